// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC handshake, imem req/gnt/rvalid bus, flush and FIFO head.
// slave = fetch unit side, master = PC stage / memory / decoder side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              instr_fault;

  modport slave (
    input  pc_in, pc_valid, flush,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  instr_ready,
    output pc_ready, imem_req, imem_addr,
    output instr_valid, instr, instr_pc,
    output instr_fault
  );

  modport master (
    output pc_in, pc_valid, flush,
    output imem_gnt, imem_rvalid, imem_rdata,
    output instr_ready,
    input  pc_ready, imem_req, imem_addr,
    input  instr_valid, instr, instr_pc,
    input  instr_fault
  );
`else
  modport slave (
    input  pc_in, pc_valid, flush,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  instr_ready,
    output pc_ready, imem_req, imem_addr,
    output instr_valid, instr, instr_pc
  );

  modport master (
    output pc_in, pc_valid, flush,
    output imem_gnt, imem_rvalid, imem_rdata,
    output instr_ready,
    input  pc_ready, imem_req, imem_addr,
    input  instr_valid, instr, instr_pc
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one-outstanding imem fetch with {pc,instr} output FIFO and flush.
// Ports: clk, rst_n (sync, active-low), bus (slave); FETCH_MISALIGN_CHK_EN adds fault entries.
module instr_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.slave  bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_GNT  = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] DRAIN     = 2'd3;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);
`endif

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] data_q [BUF_DEPTH];
  logic [ADDR_W-1:0] fpc_q  [BUF_DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
  logic              fault_q [BUF_DEPTH];
`endif

  logic              pc_ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_data;
  logic              push_fault;

  assign pc_ready = (state_q == IDLE) && !bus.flush
                 && (cnt_q < CNT_W'(BUF_DEPTH));
  assign accept   = bus.pc_valid && pc_ready;
  assign pop      = (cnt_q != '0) && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_pc    = pc_q;
    push_data  = bus.imem_rdata;
    push_fault = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef FETCH_MISALIGN_CHK_EN
          if (bus.pc_in[1:0] != 2'b00) begin
            push       = 1'b1;
            push_pc    = bus.pc_in;
            push_data  = NOP;
            push_fault = 1'b1;
          end else begin
`else
          begin
`endif
            req_d   = 1'b1;
            addr_d  = {bus.pc_in[ADDR_W-1:2], 2'b00};
            pc_d    = bus.pc_in;
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (bus.flush) begin
          req_d   = 1'b0;
          // a grant in the flush cycle still owes us a beat
          state_d = bus.imem_gnt ? DRAIN : IDLE;
        end else if (bus.imem_gnt) begin
          req_d   = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.imem_rvalid) begin
          push    = !bus.flush;
          state_d = IDLE;
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i]  <= '0;
        fpc_q[i]   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_q[i] <= 1'b0;
`endif
      end
    end else if (push && !bus.flush) begin
      data_q[wr_ptr_q]  <= push_data;
      fpc_q[wr_ptr_q]   <= push_pc;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q[wr_ptr_q] <= push_fault;
`endif
    end
  end

`ifndef FETCH_MISALIGN_CHK_EN
  logic unused_fault;
  assign unused_fault = push_fault;
`endif

  assign bus.pc_ready    = pc_ready;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (cnt_q != '0);
  assign bus.instr       = data_q[rd_ptr_q];
  assign bus.instr_pc    = fpc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHK_EN
  assign bus.instr_fault = fault_q[rd_ptr_q];
`endif

endmodule
